// File: rtl/facto_pkg.sv
// Shared definitions for the factorial-core bus master: register map,
// FSM state encoding and the one-beat bus command record.
package facto_pkg;

  localparam logic [15:0] FACTO_BASE_ADDR = 16'h7000;

  localparam logic [15:0] OFF_START = 16'h0000;
  localparam logic [15:0] OFF_CLEAR = 16'h0008;
  localparam logic [15:0] OFF_DONE  = 16'h0010;
  localparam logic [15:0] OFF_INTR  = 16'h0018;
  localparam logic [15:0] OFF_OPER  = 16'h0020;
  localparam logic [15:0] OFF_RESH  = 16'h0028;
  localparam logic [15:0] OFF_RESL  = 16'h0030;

  typedef enum logic [3:0] {
    IDLE,
    CLR_SET,
    CLR_REL,
    WR_OPER,
    WR_INTR,
    WR_START,
    WAIT,
    RD_H,
    CAP_H,
    RD_L,
    CAP_L,
    FIN
  } state_t;

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [15:0] addr;
    logic [63:0] data;
  } bus_cmd_t;

  function automatic bus_cmd_t bus_wr(input logic [15:0] addr, input logic [63:0] data);
    bus_cmd_t c;
    c.vld  = 1'b1;
    c.wr   = 1'b1;
    c.addr = addr;
    c.data = data;
    return c;
  endfunction

  function automatic bus_cmd_t bus_rd(input logic [15:0] addr);
    bus_cmd_t c;
    c.vld  = 1'b1;
    c.wr   = 1'b0;
    c.addr = addr;
    c.data = 64'd0;
    return c;
  endfunction

endpackage

// File: rtl/facto_bus_beat.sv
// Bus beat driver: turns a one-cycle command into a registered single-cycle
// m_sel beat; with no command the bus rests at all zeros.
module facto_bus_beat
  import facto_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  bus_cmd_t    cmd,
  output logic        m_sel,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout
);

  // register the command onto the bus, zeroing every field between beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sel  <= 1'b0;
      m_wr   <= 1'b0;
      m_addr <= 16'd0;
      m_dout <= 64'd0;
    end else if (cmd.vld) begin
      m_sel  <= 1'b1;
      m_wr   <= cmd.wr;
      m_addr <= cmd.addr;
      m_dout <= cmd.data;
    end else begin
      m_sel  <= 1'b0;
      m_wr   <= 1'b0;
      m_addr <= 16'd0;
      m_dout <= 64'd0;
    end
  end

endmodule

// File: rtl/facto_master.sv
// Bus master that sequences one factorial computation on the core:
// clear, load operand, start, wait for completion, read the 128-bit result.
// Build option FACTO_MASTER_IRQ_EN: wait on the interrupt pin instead of
// polling the DONE register.
//
// state    | meaning
// IDLE     | waiting for req
// CLR_SET  | write CLEAR=1
// CLR_REL  | write CLEAR=0
// WR_OPER  | write OPER={32'b0,operand}
// WR_INTR  | write INTR (1 in irq build, else 0)
// WR_START | write START=1
// WAIT     | poll DONE / wait for interrupt, bounded by TIMEOUT
// RD_H     | read RESH
// CAP_H    | capture RESH into result[127:64]
// RD_L     | read RESL
// CAP_L    | capture RESL into result[63:0]
// FIN      | write CLEAR=1, pulse done
//
// Bus commands are decoded from the next state so that the registered beat
// lines up with the state it belongs to; read data then arrives in the
// following state (CAP_x, or the WAIT check cycle).
module facto_master
  import facto_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = FACTO_BASE_ADDR,
  parameter logic [31:0] TIMEOUT   = 32'd65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [31:0]  operand,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] result,
  output logic         m_sel,
  output logic         m_wr,
  output logic [15:0]  m_addr,
  output logic [63:0]  m_dout,
  input  logic [63:0]  m_din,
  input  logic         interrupt
);

  state_t        state_q;
  state_t        state_d;
  logic [31:0]   op_q;
  logic [31:0]   wait_cnt;
  logic [31:0]   cnt_inc;
  logic          wait_tc;
  logic          core_done;
  logic          err_q;
  logic [127:0]  result_q;
  bus_cmd_t      cmd;

`ifdef FACTO_MASTER_IRQ_EN
  localparam logic [63:0] INTR_VAL = 64'd1;
  assign core_done = interrupt;
`else
  localparam logic [63:0] INTR_VAL = 64'd0;
  logic unused_irq;
  assign unused_irq = interrupt;
  // a WAIT cycle without a beat is the check cycle after a DONE read
  assign core_done = !m_sel && m_din[0];
`endif

  assign cnt_inc = (wait_cnt == TIMEOUT) ? wait_cnt : wait_cnt + 32'd1;
  assign wait_tc = (cnt_inc == TIMEOUT);
  assign err     = err_q;
  assign result  = result_q;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req) state_d = CLR_SET;
      CLR_SET:  state_d = CLR_REL;
      CLR_REL:  state_d = WR_OPER;
      WR_OPER:  state_d = WR_INTR;
      WR_INTR:  state_d = WR_START;
      WR_START: state_d = WAIT;
      WAIT: begin
        if (core_done)    state_d = RD_H;
        else if (wait_tc) state_d = FIN;
      end
      RD_H:     state_d = CAP_H;
      CAP_H:    state_d = RD_L;
      RD_L:     state_d = CAP_L;
      CAP_L:    state_d = FIN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // status outputs and the bus command for the state being entered
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FIN);
    cmd  = '0;
    case (state_d)
      CLR_SET:  cmd = bus_wr(BASE_ADDR + OFF_CLEAR, 64'd1);
      CLR_REL:  cmd = bus_wr(BASE_ADDR + OFF_CLEAR, 64'd0);
      WR_OPER:  cmd = bus_wr(BASE_ADDR + OFF_OPER, {32'd0, op_q});
      WR_INTR:  cmd = bus_wr(BASE_ADDR + OFF_INTR, INTR_VAL);
      WR_START: cmd = bus_wr(BASE_ADDR + OFF_START, 64'd1);
      WAIT: begin
`ifndef FACTO_MASTER_IRQ_EN
        if (state_q != WAIT || !m_sel) cmd = bus_rd(BASE_ADDR + OFF_DONE);
`endif
      end
      RD_H:     cmd = bus_rd(BASE_ADDR + OFF_RESH);
      RD_L:     cmd = bus_rd(BASE_ADDR + OFF_RESL);
      FIN:      cmd = bus_wr(BASE_ADDR + OFF_CLEAR, 64'd1);
      default:  cmd = '0;
    endcase
  end

  // operand latch, WAIT timeout counter, error flag and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= 32'd0;
      wait_cnt <= 32'd0;
      err_q    <= 1'b0;
      result_q <= 128'd0;
    end else begin
      if (state_q == IDLE && req) begin
        op_q     <= operand;
        err_q    <= 1'b0;
        result_q <= 128'd0;
      end
      if (state_q == WAIT) wait_cnt <= cnt_inc;
      else                 wait_cnt <= 32'd0;
      if (state_q == WAIT && !core_done && wait_tc) begin
        err_q    <= 1'b1;
        result_q <= 128'd0;
      end
      if (state_q == CAP_H) result_q[127:64] <= m_din;
      if (state_q == CAP_L) result_q[63:0]   <= m_din;
    end
  end

  facto_bus_beat u_bus_beat (
    .clk    (clk),
    .reset  (reset),
    .cmd    (cmd),
    .m_sel  (m_sel),
    .m_wr   (m_wr),
    .m_addr (m_addr),
    .m_dout (m_dout)
  );

endmodule

// File: tb/tb_facto_master.sv
// Bench for facto_master: behavioural factorial core with registered read
// data, directed plus randomized transactions checked against a
// cycle-count/bus-trace model derived from the sequencing rules.
module tb_facto_master;

`ifdef FACTO_MASTER_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam int TMO = 100;

  localparam logic [15:0] A_START = 16'h7000;
  localparam logic [15:0] A_CLEAR = 16'h7008;
  localparam logic [15:0] A_DONE  = 16'h7010;
  localparam logic [15:0] A_INTR  = 16'h7018;
  localparam logic [15:0] A_OPER  = 16'h7020;
  localparam logic [15:0] A_RESH  = 16'h7028;
  localparam logic [15:0] A_RESL  = 16'h7030;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic [31:0]  operand;
  logic         busy, done, err;
  logic [127:0] result;
  logic         m_sel, m_wr;
  logic [15:0]  m_addr;
  logic [63:0]  m_dout;
  logic [63:0]  m_din;
  logic         interrupt;

  int n_assert = 0;
  int n_fail   = 0;
  beat_t beats[$];

  // core model state
  logic [63:0]  core_rdata = 64'd0;
  logic         core_done = 1'b0;
  logic         core_intr_en = 1'b0;
  logic [31:0]  core_op = 32'd0;
  logic [127:0] core_res = 128'd0;
  int           core_cnt = 0;
  int           core_delay;
  bit           core_hang;
  logic         irq_glitch;

  always #5 clk = ~clk;

  facto_master #(.BASE_ADDR(16'h7000), .TIMEOUT(32'd100)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .operand   (operand),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .m_sel     (m_sel),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_dout    (m_dout),
    .m_din     (m_din),
    .interrupt (interrupt)
  );

  function automatic logic [127:0] fact(input logic [31:0] n);
    logic [127:0] r = 128'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 128'(i);
    return r;
  endfunction

  function automatic beat_t mk(input logic wr, input logic [15:0] a, input logic [63:0] d);
    beat_t b;
    b.wr = wr; b.addr = a; b.data = d;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // behavioural core: register file, delayed completion, registered reads
  always @(posedge clk) begin
    if (m_sel && m_wr) begin
      if (m_addr == A_CLEAR && m_dout[0]) begin core_done <= 1'b0; core_cnt <= 0; end
      if (m_addr == A_INTR) core_intr_en <= m_dout[0];
      if (m_addr == A_OPER) core_op <= m_dout[31:0];
      if (m_addr == A_START && m_dout[0] && !core_hang) begin
        if (core_delay == 0) begin core_done <= 1'b1; core_res <= fact(core_op); end
        else core_cnt <= core_delay;
      end
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end else if (core_cnt == 1) begin
      core_done <= 1'b1; core_res <= fact(core_op); core_cnt <= 0;
    end
    if (m_sel && !m_wr) begin
      case (m_addr)
        A_DONE:  core_rdata <= {63'd0, core_done};
        A_RESH:  core_rdata <= core_res[127:64];
        A_RESL:  core_rdata <= core_res[63:0];
        default: core_rdata <= 64'd0;
      endcase
    end
  end
  assign m_din     = core_rdata;
  assign interrupt = (core_done & core_intr_en) | irq_glitch;

  // bus monitor: record beats, bus must rest at zero between beats
  always @(negedge clk) begin
    if (m_sel) beats.push_back(mk(m_wr, m_addr, m_dout));
    else if (!reset) chk("idle_bus", 128'({m_wr, m_addr, m_dout}), 128'd0);
  end

  task automatic run_txn(input logic [31:0] op, input int delay, input bit hang, input bit glitch);
    int lat, exp_lat, exp_reads;
    bit seen;
    beat_t e[$];
    logic [127:0] exp_res;
    @(negedge clk);
    beats.delete();
    operand = op; req = 1'b1; core_delay = delay; core_hang = hang; irq_glitch = glitch;
    lat = 0; seen = 0;
    while (!seen && lat < 400) begin
      @(negedge clk);
      lat++;
      req = 1'b0;
      irq_glitch = glitch && (lat < 5);
      if (lat == 1) chk("busy_rise", 128'(busy), 128'd1);
      if (done) seen = 1;
    end
    irq_glitch = 1'b0;
    chk("done_seen", 128'(seen), 128'd1);
    exp_res = hang ? 128'd0 : fact(op);
    if (hang) begin
      exp_lat = 6 + TMO;
      exp_reads = IRQ ? 0 : (TMO + 1) / 2;
    end else begin
      exp_lat = IRQ ? 11 + delay : 12 + 2 * ((delay + 1) / 2);
      exp_reads = IRQ ? 0 : (delay + 1) / 2 + 1;
    end
    chk($sformatf("latency op=%0d d=%0d", op, delay), 128'(lat), 128'(exp_lat));
    chk($sformatf("result op=%0d", op), result, exp_res);
    chk("err", 128'(err), 128'(hang));
    @(negedge clk);
    chk("done_pulse_width", 128'(done), 128'd0);
    chk("busy_fall", 128'(busy), 128'd0);
    chk("result_hold", result, exp_res);
    e.push_back(mk(1'b1, A_CLEAR, 64'd1));
    e.push_back(mk(1'b1, A_CLEAR, 64'd0));
    e.push_back(mk(1'b1, A_OPER, {32'd0, op}));
    e.push_back(mk(1'b1, A_INTR, 64'(IRQ)));
    e.push_back(mk(1'b1, A_START, 64'd1));
    for (int i = 0; i < exp_reads; i++) e.push_back(mk(1'b0, A_DONE, 64'd0));
    if (!hang) begin
      e.push_back(mk(1'b0, A_RESH, 64'd0));
      e.push_back(mk(1'b0, A_RESL, 64'd0));
    end
    e.push_back(mk(1'b1, A_CLEAR, 64'd1));
    chk("beat_count", 128'(beats.size()), 128'(e.size()));
    for (int i = 0; i < e.size() && i < beats.size(); i++)
      chk($sformatf("beat%0d", i), 128'(beats[i]), 128'(e[i]));
  endtask

  initial begin
    int dn, acc, st;
    bit found, idle_seen;
    reset = 1'b1; req = 1'b0; operand = 32'd0;
    core_delay = 0; core_hang = 0; irq_glitch = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_bus", 128'({m_sel, m_wr, m_addr, m_dout}), 128'd0);
    chk("rst_result", result, 128'd0);
    reset = 1'b0;

    run_txn(32'd5, 0, 0, 0);
    chk("fact5", result, 128'd120);
    run_txn(32'd20, 3, 0, 1);
    chk("fact20", result, 128'h21C3677C82B40000);
    run_txn(32'd0, 0, 0, 0);
    chk("fact0", result, 128'd1);
    run_txn(32'd1, 0, 0, 0);
    chk("fact1", result, 128'd1);

    for (int k = 0; k < 6; k++)
      run_txn(32'($urandom_range(0, 30)), int'($urandom_range(0, 9)), 0, 1'($urandom_range(0, 1)));

    run_txn(32'd11, 0, 1, 0);
    chk("timeout_err", 128'(err), 128'd1);
    chk("timeout_result", result, 128'd0);

    // reset while in CAP_H
    @(negedge clk);
    beats.delete();
    operand = 32'd7; req = 1'b1; core_delay = 0; core_hang = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (m_sel && !m_wr && m_addr == A_RESH) found = 1;
    end
    chk("rd_h_seen", 128'(found), 128'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_done", 128'(done), 128'd0);
    chk("midrst_err", 128'(err), 128'd0);
    chk("midrst_bus", 128'({m_sel, m_wr, m_addr, m_dout}), 128'd0);
    chk("midrst_result", result, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    run_txn(32'd3, 0, 0, 0);
    chk("fact3_after_rst", result, 128'd6);

    // req held high: one transaction and one done per acceptance
    @(negedge clk);
    beats.delete();
    operand = 32'd9; req = 1'b1; core_delay = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin dn++; chk("held_result", result, fact(32'd9)); end
    end
    req = 1'b0;
    idle_seen = 0;
    for (int i = 0; i < 60 && !idle_seen; i++) begin
      @(negedge clk);
      if (done) begin dn++; chk("held_result", result, fact(32'd9)); end
      if (!busy && !done) idle_seen = 1;
    end
    chk("held_idle", 128'(idle_seen), 128'd1);
    acc = 0; st = 0;
    foreach (beats[i]) begin
      if (beats[i].wr && beats[i].addr == A_CLEAR && beats[i].data == 64'd0) acc++;
      if (beats[i].wr && beats[i].addr == A_START) st++;
    end
    chk("held_accepts_vs_done", 128'(acc), 128'(dn));
    chk("held_starts_vs_done", 128'(st), 128'(dn));
    chk("held_multiple", 128'(dn >= 2), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
